// File: rtl/xevious_input_pkg.sv
// xevious_input_pkg: scan codes, joystick/key indices, coin FSM states and DIP constants
package xevious_input_pkg;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BOMB  = 8'h14;
  localparam logic [8:0] SC_FIRE     = 9'h029;
  localparam logic [8:0] SC_START1_A = 9'h005;
  localparam logic [8:0] SC_START1_B = 9'h016;
  localparam logic [8:0] SC_START2_A = 9'h006;
  localparam logic [8:0] SC_START2_B = 9'h01E;
  localparam logic [8:0] SC_COIN1    = 9'h02E;
  localparam logic [8:0] SC_COIN2    = 9'h036;
  localparam logic [8:0] SC_FIRE2    = 9'h01C;
  localparam logic [8:0] SC_BOMB2    = 9'h01B;
  typedef enum logic [3:0] {
    J_RIGHT, J_LEFT, J_DOWN, J_UP, J_FIRE, J_BOMB, J_START1, J_START2, J_COIN
  } joy_idx_e;
  typedef enum int {
    K_RIGHT, K_LEFT, K_DOWN, K_UP, K_FIRE, K_BOMB, K_START1, K_START2,
    K_COIN1, K_COIN2, K_BOMB2
  } key_idx_e;
  localparam int KEY_N = 11;
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_state_e;
  localparam logic [7:0] DIP_A_RST = 8'hFF;
  localparam logic [7:0] DIP_B_RST = 8'hFD;
  localparam logic [4:0] DIP_A_LOW = 5'b11111;
  localparam logic [1:0] DIP_B_PAD = 2'b00;
  // P2 fire has no core input, so its code is consumed without selecting a key
  function automatic logic [KEY_N-1:0] key_sel(input logic [8:0] code);
    key_sel = '0;
    key_sel[K_UP]     = code[7:0] == SC_UP;
    key_sel[K_DOWN]   = code[7:0] == SC_DOWN;
    key_sel[K_LEFT]   = code[7:0] == SC_LEFT;
    key_sel[K_RIGHT]  = code[7:0] == SC_RIGHT;
    key_sel[K_BOMB]   = code[7:0] == SC_BOMB;
    key_sel[K_FIRE]   = code == SC_FIRE;
    key_sel[K_START1] = code == SC_START1_A || code == SC_START1_B;
    key_sel[K_START2] = code == SC_START2_A || code == SC_START2_B;
    key_sel[K_COIN1]  = code == SC_COIN1;
    key_sel[K_COIN2]  = code == SC_COIN2;
    key_sel[K_BOMB2]  = code == SC_BOMB2;
  endfunction
endpackage

// File: rtl/xevious_input_if.sv
// xevious_input_if: registered control and DIP bundle from the input front end to the core
// master drives all signals (input front end), slave receives them (core)
interface xevious_input_if;
  logic up, down, left, right, fire, bomb, bomb_2, start1, start2, coin;
  logic [7:0] dip_a, dip_b;
  modport master(output up, down, left, right, fire, bomb, bomb_2, start1, start2, coin, dip_a, dip_b);
  modport slave(input up, down, left, right, fire, bomb, bomb_2, start1, start2, coin, dip_a, dip_b);
endinterface

// File: rtl/xevious.sv
// xevious: the core itself is supplied by the upstream Xevious project and driven through xevious_input_if

// File: rtl/xevious_coin_stretch.sv
// xevious_coin_stretch: stretches coin_raw to at least COIN_MIN_CYCLES cycles high
// clk_sys/reset_n: clock and async active-low reset; coin_raw: merged coin request; coin: registered stretched coin
module xevious_coin_stretch import xevious_input_pkg::*; #(
  parameter int COIN_MIN_CYCLES = 1_843_200
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_raw,
  output logic coin
);
  localparam int CW = $clog2(COIN_MIN_CYCLES);
  coin_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic coin_raw_q, coin_q, coin_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (coin_raw && !coin_raw_q) begin
        state_d = PULSE;
        cnt_d = CW'(COIN_MIN_CYCLES - 1);
      end
      PULSE: if (cnt_q == '0) state_d = coin_raw ? HOLD : IDLE;
             else cnt_d = cnt_q - CW'(1);
      HOLD: if (!coin_raw) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    coin_d = state_d != IDLE;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      coin_raw_q <= 1'b0;
      coin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      coin_raw_q <= coin_raw;
      coin_q <= coin_d;
    end
  assign coin = coin_q;
endmodule

// File: rtl/xevious_input.sv
// xevious_input: ps2_key/joystick merge, coin stretching and DIP encoding for the Xevious core
// ps2_key: MiSTer toggle-protocol key event; joy: HPS joystick word; clear: zero key states;
// lives/difficulty/flags_no_bonus: OSD options; core: registered controls and DIP bytes to the core
module xevious_input import xevious_input_pkg::*; #(
  parameter int COIN_MIN_CYCLES = 1_843_200
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        clear,
  input  logic [1:0]  lives,
  input  logic [1:0]  difficulty,
  input  logic        flags_no_bonus,
  xevious_input_if.master core
);
  logic primed_q, primed_d, toggle_q, toggle_d, ev, coin_raw, coin, unused_joy;
  logic [KEY_N-1:0] keys_q, keys_d, sel;
  logic [8:0] btn_q, btn_d;
  logic [7:0] dip_a_q, dip_a_d, dip_b_q, dip_b_d;
  // btn_q[7:0] follows the joystick bit order; btn_q[8] is bomb_2
  always_comb begin
    sel = key_sel(ps2_key[8:0]);
    ev = primed_q && ps2_key[10] != toggle_q;
    primed_d = 1'b1;
    toggle_d = ps2_key[10];
    keys_d = clear ? '0 : ev ? (keys_q & ~sel) | (sel & {KEY_N{ps2_key[9]}}) : keys_q;
    coin_raw = keys_q[K_COIN1] | keys_q[K_COIN2] | joy[J_COIN];
    btn_d = {keys_q[K_BOMB2] | joy[J_BOMB], keys_q[K_START2:K_RIGHT] | joy[7:0]};
    dip_a_d = {1'b1, ~lives, DIP_A_LOW};
    dip_b_d = {1'b1, ~difficulty, ~btn_q[8], DIP_B_PAD, ~flags_no_bonus, ~btn_q[J_BOMB]};
    unused_joy = ^joy[15:9];
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      primed_q <= 1'b0;
      toggle_q <= 1'b0;
      keys_q <= '0;
      btn_q <= '0;
      dip_a_q <= DIP_A_RST;
      dip_b_q <= DIP_B_RST;
    end else begin
      primed_q <= primed_d;
      toggle_q <= toggle_d;
      keys_q <= keys_d;
      btn_q <= btn_d;
      dip_a_q <= dip_a_d;
      dip_b_q <= dip_b_d;
    end
  xevious_coin_stretch #(.COIN_MIN_CYCLES(COIN_MIN_CYCLES)) u_coin (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .coin_raw(coin_raw),
    .coin(coin)
  );
  assign core.right = btn_q[J_RIGHT];
  assign core.left = btn_q[J_LEFT];
  assign core.down = btn_q[J_DOWN];
  assign core.up = btn_q[J_UP];
  assign core.fire = btn_q[J_FIRE];
  assign core.bomb = btn_q[J_BOMB];
  assign core.start1 = btn_q[J_START1];
  assign core.start2 = btn_q[J_START2];
  assign core.bomb_2 = btn_q[8];
  assign core.coin = coin;
  assign core.dip_a = dip_a_q;
  assign core.dip_b = dip_b_q;
endmodule

// File: tb/tb_xevious_input.sv
// tb_xevious_input: directed self-checking bench for xevious_input with an 8-cycle coin minimum
module tb_xevious_input;
  logic clk_sys = 1'b0;
  logic reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic clear, flags_no_bonus, tg;
  logic [1:0] lives, difficulty;
  int tests = 0;
  int fails = 0;
  int n;
  always #5 clk_sys = ~clk_sys;
  xevious_input_if core_if();
  xevious_input #(.COIN_MIN_CYCLES(8)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .joy(joy),
    .clear(clear),
    .lives(lives),
    .difficulty(difficulty),
    .flags_no_bonus(flags_no_bonus),
    .core(core_if.master)
  );
  function automatic logic [9:0] outs();
    return {core_if.coin, core_if.bomb_2, core_if.start2, core_if.start1, core_if.bomb,
            core_if.fire, core_if.up, core_if.down, core_if.left, core_if.right};
  endfunction
  task automatic tick(input int k);
    repeat (k) @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic ev(input logic p, input logic [8:0] code);
    tg = ~tg;
    ps2_key = {tg, p, code};
  endtask
  initial begin
    tg = 1'b1;
    ps2_key = 11'h675;
    joy = '0;
    clear = 1'b0;
    lives = 2'b00;
    difficulty = 2'b00;
    flags_no_bonus = 1'b0;
    reset_n = 1'b0;
    tick(3);
    chk("rst_dip_a", core_if.dip_a, 8'hFF);
    chk("rst_dip_b", core_if.dip_b, 8'hFD);
    chk("rst_outs", outs(), 10'h000);
    reset_n = 1'b1;
    tick(3);
    chk("no_spurious", outs(), 10'h000);
    chk("dip_b_idle", core_if.dip_b, 8'hF3);
    ev(1'b1, 9'h175);
    tick(1);
    chk("up_lat1", outs(), 10'h000);
    tick(1);
    chk("up_press", outs(), 10'h008);
    ev(1'b0, 9'h075);
    tick(2);
    chk("up_rel", outs(), 10'h000);
    ev(1'b1, 9'h072);
    tick(2);
    chk("down_noE0", outs(), 10'h004);
    ev(1'b0, 9'h072);
    tick(2);
    ev(1'b1, 9'h114);
    tick(2);
    chk("bomb_E0", outs(), 10'h020);
    tick(1);
    chk("dip_b_bomb", core_if.dip_b, 8'hF2);
    ev(1'b0, 9'h014);
    tick(2);
    ev(1'b1, 9'h105);
    tick(2);
    chk("start1_exact", outs(), 10'h000);
    ev(1'b1, 9'h016);
    tick(2);
    chk("start1_alt", outs(), 10'h040);
    ev(1'b0, 9'h005);
    tick(2);
    chk("start1_rel", outs(), 10'h000);
    ev(1'b1, 9'h01B);
    tick(2);
    chk("bomb2_key", outs(), 10'h100);
    ev(1'b0, 9'h01B);
    tick(2);
    ev(1'b1, 9'h06B);
    tick(2);
    chk("left_press", outs(), 10'h002);
    ev(1'b1, 9'h0AA);
    tick(2);
    chk("unmapped", outs(), 10'h002);
    ev(1'b0, 9'h06B);
    tick(2);
    chk("after_unmapped", outs(), 10'h000);
    ev(1'b1, 9'h029);
    tick(2);
    chk("fire_press", outs(), 10'h010);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    chk("clear_fire", outs(), 10'h000);
    ev(1'b0, 9'h029);
    tick(2);
    chk("rel_after_clear", outs(), 10'h000);
    clear = 1'b1;
    ev(1'b1, 9'h029);
    tick(1);
    clear = 1'b0;
    tick(2);
    chk("clear_wins", outs(), 10'h000);
    ev(1'b1, 9'h029);
    tick(2);
    chk("toggle_tracked", outs(), 10'h010);
    ev(1'b0, 9'h029);
    tick(2);
    joy = 16'h0010;
    tick(1);
    chk("joy_fire", outs(), 10'h010);
    joy = 16'h00FF;
    tick(1);
    chk("joy_all", outs(), 10'h1FF);
    joy = 16'h0000;
    tick(1);
    chk("joy_none", outs(), 10'h000);
    ev(1'b1, 9'h02E);
    tick(2);
    chk("coin_key", core_if.coin, 1'b1);
    ev(1'b0, 9'h02E);
    tick(12);
    chk("coin_key_end", core_if.coin, 1'b0);
    joy = 16'h0100;
    tick(1);
    joy = 16'h0000;
    chk("coin_rise", core_if.coin, 1'b1);
    n = 0;
    while (core_if.coin && n < 40) begin
      n++;
      tick(1);
    end
    chk("coin_min", n, 8);
    tick(2);
    joy = 16'h0100;
    n = 0;
    repeat (20) begin
      tick(1);
      n += int'(core_if.coin);
    end
    joy = 16'h0000;
    chk("coin_hold_n", n, 20);
    tick(1);
    chk("coin_hold_drop", core_if.coin, 1'b0);
    tick(2);
    joy = 16'h0100;
    tick(1);
    joy = 16'h0000;
    tick(2);
    joy = 16'h0100;
    tick(1);
    joy = 16'h0000;
    n = 3;
    while (core_if.coin && n < 40) begin
      n++;
      tick(1);
    end
    chk("coin_no_extend", n, 8);
    lives = 2'b01;
    difficulty = 2'b10;
    flags_no_bonus = 1'b1;
    joy = 16'h0020;
    tick(1);
    chk("dip_a_opts", core_if.dip_a, 8'hDF);
    chk("dip_b_lat1", core_if.dip_b, 8'hB1);
    tick(1);
    chk("dip_b_opts", core_if.dip_b, 8'hA0);
    joy = 16'h0100;
    tick(2);
    chk("coin_pre_rst", core_if.coin, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_coin", core_if.coin, 1'b0);
    chk("rst_async_dip_a", core_if.dip_a, 8'hFF);
    joy = 16'h0000;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    chk("post_rst_idle", core_if.coin, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
